// File: rtl/tlk2711_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tlk2711_rx_checker
// Purpose  : Receive-lane checker for the TLK2711 interface. It finds frames
//            between SOF and EOF K-words and checks that the payload is an
//            incrementing 16-bit pattern of the expected length. It exposes
//            frame and error counters and one-cycle status pulses.
// Options  : TLK2711_CHK_LOSS_EN - adds a K-word watchdog that drives o_loss
//            and holds the framer in IDLE while sync is lost.
// Revision : 1.0 - initial release
// ============================================================================
module tlk2711_rx_checker #(
  parameter logic [7:0]  K_CHAR       = 8'hBC,
  parameter logic [7:0]  SOF_TYPE     = 8'hFB,
  parameter logic [7:0]  EOF_TYPE     = 8'hFD,
  parameter logic [15:0] PATTERN_INC  = 16'h0001,
  parameter logic [15:0] LOSS_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_clr,
  input  logic [15:0] i_exp_len,
  input  logic        i_2711_rkmsb,
  input  logic        i_2711_rklsb,
  input  logic [15:0] i_2711_rxd,
  output logic        o_frame_done,
  output logic        o_len_err,
  output logic        o_data_err,
  output logic [15:0] o_last_len,
  output logic [31:0] o_frame_cnt,
  output logic [31:0] o_err_cnt,
  output logic        o_err_sticky,
  output logic        o_loss
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  // Registered lane word; every decision below is taken on these.
  logic [15:0] r_rxd;
  logic        r_rkmsb;
  logic        r_rklsb;

  // Per-frame tracking.
  logic [15:0] r_count;
  logic [15:0] r_prev;
  logic        r_first;
  logic        r_ferr;
  logic [15:0] w_count_nx;
  logic [15:0] w_prev_nx;
  logic        w_first_nx;
  logic        w_ferr_nx;

  // Status pulses and counters.
  logic        r_done;
  logic        r_len_err;
  logic        r_data_err;
  logic [15:0] r_last_len;
  logic [31:0] r_frame_cnt;
  logic [31:0] r_err_cnt;
  logic        r_sticky;
  logic        w_done;
  logic        w_len_err;
  logic        w_data_err;
  logic        w_close;
  logic        w_bad_close;

  // Word classification.
  logic        w_is_k;
  logic        w_is_sof;
  logic        w_is_eof;
  logic        w_is_pay;
  logic [15:0] w_exp_word;
  logic [15:0] w_count_inc;
  logic        w_len_mis;
  logic        w_loss_block;

  // Input register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd   <= 16'd0;
      r_rkmsb <= 1'b0;
      r_rklsb <= 1'b0;
    end else begin
      r_rxd   <= i_2711_rxd;
      r_rkmsb <= i_2711_rkmsb;
      r_rklsb <= i_2711_rklsb;
    end
  end

  // The K flag of the upper byte does not qualify a K-word; only the low
  // byte carries the comma, the high byte carries the frame marker type.
  assign w_is_k      = r_rklsb && (r_rxd[7:0] == K_CHAR);
  assign w_is_sof    = w_is_k && (r_rxd[15:8] == SOF_TYPE);
  assign w_is_eof    = w_is_k && (r_rxd[15:8] == EOF_TYPE);
  assign w_is_pay    = !r_rkmsb && !r_rklsb;
  assign w_exp_word  = r_prev + PATTERN_INC;
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
  assign w_len_mis   = (i_exp_len != 16'd0) && (r_count != i_exp_len);

`ifdef TLK2711_CHK_LOSS_EN
  logic [15:0] r_loss_cnt;
  logic        r_loss;
  logic [15:0] w_loss_cnt_nx;

  assign w_loss_cnt_nx = (r_loss_cnt == 16'hFFFF) ? r_loss_cnt : r_loss_cnt + 16'd1;

  // K-word watchdog: count words since the last K-word, flag loss on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= 16'd0;
      r_loss     <= 1'b0;
    end else if (w_is_k) begin
      r_loss_cnt <= 16'd0;
      r_loss     <= 1'b0;
    end else begin
      r_loss_cnt <= w_loss_cnt_nx;
      if (w_loss_cnt_nx >= LOSS_TIMEOUT) begin
        r_loss <= 1'b1;
      end
    end
  end

  // The K-word that ends a loss episode is processed normally.
  assign w_loss_block = r_loss && !w_is_k;
  assign o_loss       = r_loss;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^LOSS_TIMEOUT;
  assign w_loss_block = 1'b0;
  assign o_loss       = 1'b0;
`endif

  // Framer next-state and per-word decisions.
  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_prev_nx   = r_prev;
    w_first_nx  = r_first;
    w_ferr_nx   = r_ferr;
    w_done      = 1'b0;
    w_len_err   = 1'b0;
    w_data_err  = 1'b0;
    w_close     = 1'b0;
    w_bad_close = 1'b0;
    if (!i_enable || w_loss_block) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_sof) begin
            w_state_nx = S_FRAME;
            w_count_nx = 16'd0;
            w_ferr_nx  = 1'b0;
            w_first_nx = 1'b1;
          end
        end
        S_FRAME: begin
          if (w_is_sof) begin
            // A new SOF truncates the open frame and starts a fresh one.
            w_len_err   = 1'b1;
            w_close     = 1'b1;
            w_bad_close = 1'b1;
            w_count_nx  = 16'd0;
            w_ferr_nx   = 1'b0;
            w_first_nx  = 1'b1;
          end else if (w_is_eof) begin
            w_done      = 1'b1;
            w_close     = 1'b1;
            w_len_err   = w_len_mis;
            w_bad_close = r_ferr || w_len_mis;
            w_state_nx  = S_IDLE;
          end else if (w_is_k) begin
            w_state_nx = S_FRAME;
          end else if (w_is_pay) begin
            if (r_first) begin
              w_first_nx = 1'b0;
            end else if (r_rxd != w_exp_word) begin
              w_data_err = 1'b1;
              w_ferr_nx  = 1'b1;
            end
            w_prev_nx  = r_rxd;
            w_count_nx = w_count_inc;
          end else begin
            w_data_err = 1'b1;
            w_ferr_nx  = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Framer state and per-frame tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= 16'd0;
      r_prev     <= 16'd0;
      r_first    <= 1'b0;
      r_ferr     <= 1'b0;
      r_done     <= 1'b0;
      r_len_err  <= 1'b0;
      r_data_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_count    <= w_count_nx;
      r_prev     <= w_prev_nx;
      r_first    <= w_first_nx;
      r_ferr     <= w_ferr_nx;
      r_done     <= w_done;
      r_len_err  <= w_len_err;
      r_data_err <= w_data_err;
    end
  end

  // Counters, last length and sticky flag; a clear overrides any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_len  <= 16'd0;
      r_frame_cnt <= 32'd0;
      r_err_cnt   <= 32'd0;
      r_sticky    <= 1'b0;
    end else if (i_clr) begin
      r_last_len  <= 16'd0;
      r_frame_cnt <= 32'd0;
      r_err_cnt   <= 32'd0;
      r_sticky    <= 1'b0;
    end else begin
      if (w_close) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
        r_last_len  <= r_count;
      end
      if (w_bad_close) begin
        r_err_cnt <= r_err_cnt + 32'd1;
      end
      if (w_len_err || w_data_err) begin
        r_sticky <= 1'b1;
      end
    end
  end

  assign o_frame_done = r_done;
  assign o_len_err    = r_len_err;
  assign o_data_err   = r_data_err;
  assign o_last_len   = r_last_len;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlk2711_rx_checker
// Purpose  : Directed-vector bench for tlk2711_rx_checker with a frame-level
//            reference model compared every cycle plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlk2711_rx_checker;

  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic        i_clr;
  logic [15:0] i_exp_len;
  logic        i_2711_rkmsb;
  logic        i_2711_rklsb;
  logic [15:0] i_2711_rxd;
  logic        o_frame_done;
  logic        o_len_err;
  logic        o_data_err;
  logic [15:0] o_last_len;
  logic [31:0] o_frame_cnt;
  logic [31:0] o_err_cnt;
  logic        o_err_sticky;
  logic        o_loss;

  always #5 clk = ~clk;

  tlk2711_rx_checker #(.LOSS_TIMEOUT(16'(LT))) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_clr        (i_clr),
    .i_exp_len    (i_exp_len),
    .i_2711_rkmsb (i_2711_rkmsb),
    .i_2711_rklsb (i_2711_rklsb),
    .i_2711_rxd   (i_2711_rxd),
    .o_frame_done (o_frame_done),
    .o_len_err    (o_len_err),
    .o_data_err   (o_data_err),
    .o_last_len   (o_last_len),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_err_sticky (o_err_sticky),
    .o_loss       (o_loss)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_len  = 0;
  int n_data = 0;
  bit saw_loss = 1'b0;
  int snap;

  // ---------------- reference model ----------------
  logic [15:0] m_rxd;
  logic        m_km, m_kl;
  bit          m_isk, m_sof, m_eof;
  bit          m_in_frame, m_bad;
  logic [15:0] m_frame[$];
  logic [15:0] m_nk;
  logic        e_done, e_len, e_data, e_sticky, e_loss;
  logic [15:0] e_last;
  logic [31:0] e_fcnt, e_ecnt;

  // Word seen at an edge is judged at the following edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rxd = '0; m_km = 1'b0; m_kl = 1'b0;
      m_in_frame = 1'b0; m_bad = 1'b0; m_frame.delete();
      m_nk = '0;
      e_done = 1'b0; e_len = 1'b0; e_data = 1'b0; e_sticky = 1'b0; e_loss = 1'b0;
      e_last = '0; e_fcnt = '0; e_ecnt = '0;
    end else begin
      m_isk = m_kl && (m_rxd[7:0] == 8'hBC);
      m_sof = m_isk && (m_rxd[15:8] == 8'hFB);
      m_eof = m_isk && (m_rxd[15:8] == 8'hFD);
      e_done = 1'b0; e_len = 1'b0; e_data = 1'b0;
      if (!i_enable || (e_loss && !m_isk)) begin
        m_in_frame = 1'b0;
        m_frame.delete();
      end else if (!m_in_frame) begin
        if (m_sof) begin
          m_in_frame = 1'b1; m_bad = 1'b0; m_frame.delete();
        end
      end else if (m_sof) begin
        e_len = 1'b1;
        e_fcnt = e_fcnt + 1;
        e_ecnt = e_ecnt + 1;
        e_last = 16'(m_frame.size());
        m_bad = 1'b0;
        m_frame.delete();
      end else if (m_eof) begin
        e_done = 1'b1;
        e_fcnt = e_fcnt + 1;
        e_last = 16'(m_frame.size());
        if (i_exp_len != 0 && m_frame.size() != int'(i_exp_len)) begin
          e_len = 1'b1; m_bad = 1'b1;
        end
        if (m_bad) e_ecnt = e_ecnt + 1;
        m_in_frame = 1'b0;
      end else if (m_isk) begin
        m_bad = m_bad;
      end else if (!m_km && !m_kl) begin
        if (m_frame.size() != 0 && m_rxd != 16'(m_frame[$] + 16'd1)) begin
          e_data = 1'b1; m_bad = 1'b1;
        end
        m_frame.push_back(m_rxd);
      end else begin
        e_data = 1'b1; m_bad = 1'b1;
      end
`ifdef TLK2711_CHK_LOSS_EN
      if (m_isk) begin
        m_nk = '0; e_loss = 1'b0;
      end else begin
        if (m_nk != 16'hFFFF) m_nk = m_nk + 16'd1;
        if (m_nk >= 16'(LT)) e_loss = 1'b1;
      end
`endif
      if (i_clr) begin
        e_fcnt = '0; e_ecnt = '0; e_last = '0; e_sticky = 1'b0;
      end else if (e_len || e_data) begin
        e_sticky = 1'b1;
      end
      m_rxd = i_2711_rxd; m_km = i_2711_rkmsb; m_kl = i_2711_rklsb;
    end
  end

  // Cycle-by-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    logic [84:0] act, exp_v;
    act   = {o_frame_done, o_len_err, o_data_err, o_last_len, o_frame_cnt, o_err_cnt, o_err_sticky, o_loss};
    exp_v = {e_done, e_len, e_data, e_last, e_fcnt, e_ecnt, e_sticky, e_loss};
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, exp_v);
    n_done += int'(o_frame_done);
    n_len  += int'(o_len_err);
    n_data += int'(o_data_err);
    if (o_loss) saw_loss = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic send(input logic kl, input logic km, input logic [15:0] d);
    i_2711_rklsb = kl; i_2711_rkmsb = km; i_2711_rxd = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b1, 1'b0, 16'hC5BC);
  endtask

  task automatic sof();  send(1'b1, 1'b0, 16'hFBBC); endtask
  task automatic eof();  send(1'b1, 1'b0, 16'hFDBC); endtask
  task automatic pay(input logic [15:0] d); send(1'b0, 1'b0, d); endtask

  task automatic clr_pulse();
    i_clr = 1'b1; idle(1); i_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b1; i_clr = 1'b0; i_exp_len = 16'd4;
    i_2711_rklsb = 1'b1; i_2711_rkmsb = 1'b0; i_2711_rxd = 16'hC5BC;
    repeat (3) @(posedge clk);
    #1;
    check("reset_frame_cnt", o_frame_cnt, 32'd0);
    check("reset_err_cnt", o_err_cnt, 32'd0);
    check("reset_last_len", {16'd0, o_last_len}, 32'd0);
    check("reset_flags", {28'd0, o_frame_done, o_len_err, o_data_err, o_err_sticky}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Clean 4-word frame.
    sof(); pay(16'h0010); pay(16'h0011); pay(16'h0012); pay(16'h0013); eof(); idle(3);
    check("t1_frame_cnt", o_frame_cnt, 32'd1);
    check("t1_err_cnt", o_err_cnt, 32'd0);
    check("t1_last_len", {16'd0, o_last_len}, 32'd4);
    check("t1_done_pulses", n_done, 1);
    check("t1_err_pulses", n_len + n_data, 0);
    check("t1_sticky", {31'd0, o_err_sticky}, 32'd0);

    // Third word breaks the pattern; fourth is relative to it.
    sof(); pay(16'h0010); pay(16'h0011); pay(16'h0020); pay(16'h0021); eof(); idle(3);
    check("t2_frame_cnt", o_frame_cnt, 32'd2);
    check("t2_err_cnt", o_err_cnt, 32'd1);
    check("t2_sticky", {31'd0, o_err_sticky}, 32'd1);
    check("t2_data_pulses", n_data, 1);

    // Short frame, then truncated frame, then good frame.
    clr_pulse(); idle(2);
    check("t3_clr_cnt", o_frame_cnt, 32'd0);
    check("t3_clr_sticky", {31'd0, o_err_sticky}, 32'd0);
    sof(); pay(16'h0100); pay(16'h0101); pay(16'h0102); eof(); idle(3);
    check("t3_short_len_pulses", n_len, 1);
    check("t3_short_last_len", {16'd0, o_last_len}, 32'd3);
    sof(); pay(16'h0200); pay(16'h0201);
    sof(); pay(16'h0500); pay(16'h0501); pay(16'h0502); pay(16'h0503); eof(); idle(3);
    check("t3_frame_cnt", o_frame_cnt, 32'd3);
    check("t3_err_cnt", o_err_cnt, 32'd2);
    check("t3_len_pulses", n_len, 2);
    check("t3_last_len", {16'd0, o_last_len}, 32'd4);

    // Pattern wrap with length check off; stray EOF in IDLE.
    clr_pulse(); i_exp_len = 16'd0; idle(2);
    sof(); pay(16'hFFFE); pay(16'hFFFF); pay(16'h0000); pay(16'h0001); eof(); idle(3);
    check("t4_frame_cnt", o_frame_cnt, 32'd1);
    check("t4_err_cnt", o_err_cnt, 32'd0);
    check("t4_data_pulses", n_data, 1);
    eof(); idle(3);
    check("t4_stray_eof_cnt", o_frame_cnt, 32'd1);
    check("t4_done_pulses", n_done, 5);

    // Reset mid-frame, then a full frame; then clear coincident with EOF.
    i_exp_len = 16'd4;
    sof(); pay(16'h0040); pay(16'h0041);
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(2);
    sof(); pay(16'h0050); pay(16'h0051); pay(16'h0052); pay(16'h0053); eof(); idle(3);
    check("t5_frame_cnt", o_frame_cnt, 32'd1);
    check("t5_err_cnt", o_err_cnt, 32'd0);
    sof(); pay(16'h0060); pay(16'h0061); pay(16'h0062); pay(16'h0063); eof();
    clr_pulse(); idle(2);
    check("t5_clr_eof_cnt", o_frame_cnt, 32'd0);
    check("t5_clr_eof_len", {16'd0, o_last_len}, 32'd0);

    // Enable dropped mid-frame discards it; later EOF is stray.
    snap = n_done;
    sof(); pay(16'h0070); pay(16'h0071);
    i_enable = 1'b0; idle(2); i_enable = 1'b1;
    eof(); idle(3);
    check("t7_enable_cnt", o_frame_cnt, 32'd0);
    check("t7_enable_done", n_done, snap);

    // Long run of payload without any K-word.
    i_exp_len = 16'd0; idle(2);
    sof();
    for (int i = 0; i < 20; i++) pay(16'(i));
    eof(); idle(3);
`ifdef TLK2711_CHK_LOSS_EN
    check("t6_loss_seen", {31'd0, saw_loss}, 32'd1);
    check("t6_loss_frame_cnt", o_frame_cnt, 32'd0);
`else
    check("t6_loss_seen", {31'd0, saw_loss}, 32'd0);
    check("t6_long_frame_len", {16'd0, o_last_len}, 32'd20);
`endif
    sof(); pay(16'h0030); pay(16'h0031); pay(16'h0032); pay(16'h0033); eof(); idle(3);
    check("t6_loss_clear", {31'd0, o_loss}, 32'd0);
    check("t6_after_last_len", {16'd0, o_last_len}, 32'd4);
`ifdef TLK2711_CHK_LOSS_EN
    check("t6_after_frame_cnt", o_frame_cnt, 32'd1);
`else
    check("t6_after_frame_cnt", o_frame_cnt, 32'd2);
`endif
    check("t6_after_err_cnt", o_err_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
